// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder path.
package fft_pkg;

    localparam int BW_DEF       = 16;
    localparam int LOG2N_DEF    = 6;
    localparam int BITREV_MAX_W = 16;

    typedef enum logic [1:0] {
        BUF_EMPTY    = 2'd0,
        BUF_FILLING  = 2'd1,
        BUF_FULL     = 2'd2,
        BUF_DRAINING = 2'd3
    } buf_state_e;

    // Reverse the low w bits of v (w <= BITREV_MAX_W); upper result bits are zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                      input int unsigned w);
        logic [BITREV_MAX_W-1:0] r;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            r[i] = v[BITREV_MAX_W-1-i];
        end
        return r >> (BITREV_MAX_W - w);
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Pair-beat input stream and single-sample output stream of the FFT reorder unloader.
interface fft_out_reorder_if
    import fft_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int LOG2N = LOG2N_DEF
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic signed [BW-1:0] inReal0;
    logic signed [BW-1:0] inImag0;
    logic signed [BW-1:0] inReal1;
    logic signed [BW-1:0] inImag1;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [BW-1:0] outReal;
    logic signed [BW-1:0] outImag;
    logic [LOG2N-1:0]     out_index;
    logic                 out_last;
    logic                 ovf;

    modport master (
        output in_valid, inReal0, inImag0, inReal1, inImag1, out_ready,
        input  in_ready, out_valid, outReal, outImag, out_index, out_last, ovf
    );

    modport slave (
        input  in_valid, inReal0, inImag0, inReal1, inImag1, out_ready,
        output in_ready, out_valid, outReal, outImag, out_index, out_last, ovf
    );

endinterface

// File: rtl/reorder_buf_bank.sv
// Simple dual-port RAM bank with registered read; read data holds while re is low.
module reorder_buf_bank #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed pair beats in, natural-order samples out.
// Define FFT_OUT_REORDER_FFTSHIFT_EN to read each frame in fftshift order instead.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    fft_out_reorder_if.slave  bus
);

    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int AW   = LOG2N - 1;

    buf_state_e       state_q [2];
    buf_state_e       state_d [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [AW-1:0]    beat_cnt;
    logic [LOG2N-1:0] rd_cnt;

    logic             out_valid_q;
    logic [LOG2N-1:0] out_index_q;
    logic             sel_buf;
    logic             sel_bank;
    logic             ovf_q;

    logic             accept;
    logic             beat_last;
    logic [AW-1:0]    waddr;
    logic             hs;
    logic             load;
    logic             rd_last;
    logic             frame_cont;
    logic             can_read;
    logic             issue;
    logic             nxt_ptr;
    logic [LOG2N-1:0] nxt_cnt;
    logic [LOG2N-1:0] rbin;
    logic [2*BW-1:0]  rdata [2][2];
    logic [2*BW-1:0]  q_sel;

    // Write side: port 0 always lands in the lower half of the bins, port 1 in the upper.
    assign bus.in_ready = (state_q[wr_ptr] == BUF_EMPTY) || (state_q[wr_ptr] == BUF_FILLING);
    assign accept       = bus.in_valid && bus.in_ready;
    assign beat_last    = (beat_cnt == AW'(HALF - 1));
    assign waddr        = AW'(bitrev(BITREV_MAX_W'({beat_cnt, 1'b0}), LOG2N));

    // Read side: pick the sample that will be on the output after this edge.
    assign hs         = out_valid_q && bus.out_ready;
    assign load       = !out_valid_q || bus.out_ready;
    assign rd_last    = (rd_cnt == LOG2N'(N - 1));
    assign frame_cont = out_valid_q && !(hs && rd_last);
    assign can_read   = frame_cont || (state_q[nxt_ptr] == BUF_FULL);
    assign issue      = load && can_read;

    always_comb begin
        nxt_ptr = rd_ptr;
        nxt_cnt = rd_cnt;
        if (hs) begin
            if (rd_last) begin
                nxt_ptr = ~rd_ptr;
                nxt_cnt = '0;
            end else begin
                nxt_cnt = rd_cnt + 1'b1;
            end
        end
    end

`ifdef FFT_OUT_REORDER_FFTSHIFT_EN
    assign rbin = nxt_cnt ^ LOG2N'(HALF);
`else
    assign rbin = nxt_cnt;
`endif

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            case (state_q[b])
                BUF_EMPTY:
                    if (accept && (wr_ptr == 1'(b)))
                        state_d[b] = beat_last ? BUF_FULL : BUF_FILLING;
                BUF_FILLING:
                    if (accept && (wr_ptr == 1'(b)) && beat_last)
                        state_d[b] = BUF_FULL;
                BUF_FULL:
                    if (issue && (nxt_ptr == 1'(b)))
                        state_d[b] = BUF_DRAINING;
                BUF_DRAINING:
                    if (hs && rd_last && (rd_ptr == 1'(b)))
                        state_d[b] = BUF_EMPTY;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q[0]  <= BUF_EMPTY;
            state_q[1]  <= BUF_EMPTY;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            beat_cnt    <= '0;
            rd_cnt      <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            sel_buf     <= 1'b0;
            sel_bank    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            if (accept) begin
                beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
                if (beat_last) begin
                    wr_ptr <= ~wr_ptr;
                end
            end
            rd_ptr <= nxt_ptr;
            rd_cnt <= nxt_cnt;
            if (load) begin
                out_valid_q <= can_read;
            end
            if (issue) begin
                out_index_q <= rbin;
                sel_buf     <= nxt_ptr;
                sel_bank    <= rbin[LOG2N-1];
            end
            if (bus.in_valid && !bus.in_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_buf
        for (genvar k = 0; k < 2; k++) begin : g_bank
            reorder_buf_bank #(
                .W  (2 * BW),
                .AW (AW)
            ) u_bank (
                .clk   (clk),
                .we    (accept && (wr_ptr == 1'(b))),
                .waddr (waddr),
                .wdata ((k == 0) ? {bus.inReal0, bus.inImag0} : {bus.inReal1, bus.inImag1}),
                .re    (issue && (nxt_ptr == 1'(b)) && (rbin[LOG2N-1] == 1'(k))),
                .raddr (rbin[AW-1:0]),
                .rdata (rdata[b][k])
            );
        end
    end

    // Bank outputs hold between reads, so the selected word is stable across stalls.
    assign q_sel         = rdata[sel_buf][sel_bank];
    assign bus.out_valid = out_valid_q;
    assign bus.outReal   = out_valid_q ? q_sel[2*BW-1:BW] : '0;
    assign bus.outImag   = out_valid_q ? q_sel[BW-1:0]    : '0;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_valid_q && rd_last;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder at LOG2N=3; honours FFT_OUT_REORDER_FFTSHIFT_EN.
module tb_fft_out_reorder;

    localparam int BW    = 16;
    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int HALF  = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    always #5 clk = ~clk;

    fft_out_reorder_if #(.BW(BW), .LOG2N(LOG2N)) bus ();

    fft_out_reorder #(.BW(BW), .LOG2N(LOG2N)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_vec   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int exp_q[$];
    int exp_k   = 0;
    int t_first = -1;
    int t_done  = -1;
    bit arm     = 1'b0;
    int bin0_tab[4] = '{0, 2, 1, 3};
    int bin1_tab[4] = '{4, 6, 5, 7};
    bit pat[4]      = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int out_bin(input int k);
`ifdef FFT_OUT_REORDER_FFTSHIFT_EN
        return k ^ HALF;
`else
        return k;
`endif
    endfunction

    function automatic logic [BW-1:0] re_of(input int f, input int b);
        return BW'(16 * f + b);
    endfunction

    function automatic logic [BW-1:0] im_of(input int f, input int b);
        return BW'(-(16 * f + b));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One clock: drive a beat (optional) and out_ready, then check the displayed sample.
    task automatic step(input bit iv, input int f, input int p, input bit ordy, input bit exp_rdy);
        int fr;
        int b;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        if (iv) begin
            bus.inReal0 = re_of(f, bin0_tab[p]);
            bus.inImag0 = im_of(f, bin0_tab[p]);
            bus.inReal1 = re_of(f, bin1_tab[p]);
            bus.inImag1 = im_of(f, bin1_tab[p]);
            check("in_ready_at_offer", 32'(bus.in_ready), 32'(exp_rdy));
        end else begin
            bus.inReal0 = '0;
            bus.inImag0 = '0;
            bus.inReal1 = '0;
            bus.inImag1 = '0;
        end
        if (bus.out_valid && ordy && (exp_q.size() > 0)) begin
            exp_k++;
            if (exp_k == N) begin
                exp_k = 0;
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) t_done = cyc;
            end
        end
        tick();
        bus.in_valid = 1'b0;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                fr = exp_q[0];
                b  = out_bin(exp_k);
                check("out_index", 32'(bus.out_index), 32'(b));
                check("outReal", 32'($unsigned(bus.outReal)), 32'(re_of(fr, b)));
                check("outImag", 32'($unsigned(bus.outImag)), 32'(im_of(fr, b)));
                check("out_last", 32'(bus.out_last), 32'(exp_k == N - 1));
                if (arm && t_first < 0) t_first = cyc;
            end
        end
    endtask

    task automatic send_frame(input int f, input bit ordy);
        for (int p = 0; p < HALF; p++) step(1'b1, f, p, ordy, 1'b1);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1'b0, 0, 0, 1'b1, 1'b0);
        check(tag, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.inReal0   = '0;
        bus.inImag0   = '0;
        bus.inReal1   = '0;
        bus.inImag1   = '0;

        // Reset values
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_outReal", 32'($unsigned(bus.outReal)), 32'd0);
        check("rst_outImag", 32'($unsigned(bus.outImag)), 32'd0);
        check("rst_out_index", 32'(bus.out_index), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        nrst = 1'b1;
        tick();

        // Single frame, one-cycle read latency after the last beat
        exp_q.push_back(0);
        send_frame(0, 1'b1);
        check("t1_valid_after_last_beat", 32'(bus.out_valid), 32'd0);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        check("t1_valid_rise", 32'(bus.out_valid), 32'd1);
        drain("t1_drain", 20);

        // Back-to-back frames, no bubble between them
        exp_q.push_back(1);
        exp_q.push_back(2);
        arm     = 1'b1;
        t_first = -1;
        send_frame(1, 1'b1);
        send_frame(2, 1'b1);
        drain("t2_drain", 40);
        arm = 1'b0;
        check("t2_no_bubble", 32'(t_done - t_first), 32'd15);

        // Backpressure 1,0,0,1,...
        exp_q.push_back(3);
        send_frame(3, 1'b1);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) step(1'b0, 0, 0, pat[i % 4], 1'b0);
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // Both buffers full, third frame overflows
        exp_q.push_back(4);
        exp_q.push_back(5);
        send_frame(4, 1'b0);
        send_frame(5, 1'b0);
        check("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("t4_ovf_before", 32'(bus.ovf), 32'd0);
        step(1'b1, 6, 0, 1'b0, 1'b0);
        check("t4_ovf_set", 32'(bus.ovf), 32'd1);
        drain("t4_drain", 60);
        check("t4_ovf_sticky", 32'(bus.ovf), 32'd1);
        check("t4_in_ready_back", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset in the middle of a drain
        exp_q.push_back(7);
        send_frame(7, 1'b1);
        for (int i = 0; i < 20 && !(bus.out_valid && bus.out_index == 3); i++)
            step(1'b0, 0, 0, 1'b1, 1'b0);
        check("t5_at_index3", 32'(bus.out_index), 32'd3);
        nrst = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_out_index", 32'(bus.out_index), 32'd0);
        check("t5_rst_outReal", 32'($unsigned(bus.outReal)), 32'd0);
        check("t5_rst_outImag", 32'($unsigned(bus.outImag)), 32'd0);
        check("t5_rst_out_last", 32'(bus.out_last), 32'd0);
        check("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("t5_rst_ovf", 32'(bus.ovf), 32'd0);
        exp_q.delete();
        exp_k = 0;
        tick();
        nrst = 1'b1;
        tick();
        exp_q.push_back(8);
        send_frame(8, 1'b1);
        drain("t5_fresh_drain", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
